bomb_exp_module: RTL
====================

BOMB_EXP_MODULE -- requirements
Module: bomb_exp_module

Interface
REQ-001 Parameter FUSE_MAX, default 150000000, fuse duration in clk cycles.
REQ-002 Parameter EXP_MAX, default 50000000, explosion display duration in clk cycles.
REQ-003 Parameter POST_MAX, default 25000000, post-explosion cooldown in clk cycles.
REQ-004 Parameter EXP_LEN, default 1, explosion arm length in tiles (1-3).
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  reset, asynchronous, active-high; clock clk.
REQ-007 display_on  in  1  pixel inside visible area.
REQ-008 x, y  in  10 each  current pixel coordinates.
REQ-009 x_b, y_b  in  10 each  bomberman sprite upper-left corner.
REQ-010 btn_place  in  1  bomb place button, synchronous level.
REQ-011 bomb_on  out  1  pixel inside placed bomb tile.
REQ-012 exp_on  out  1  pixel inside an active explosion tile.
REQ-013 post_exp_active  out  1  explosion or cooldown in progress.
REQ-014 bomb_active  out  1  any state other than NO_BOMB.
REQ-015 bm_exp_hit  out  1  one-cycle pulse, explosion covers bomberman tile.
REQ-016 rgb_out  out  12  bomb/explosion colour for current pixel.

Function
REQ-017 Arena frame: xa = x - 48, ya = y - 32; tile = 16x16; valid tiles tx 0..32, ty 0..25; pillar tile when tx and ty are both odd.
REQ-018 Bomb tile is latched at placement: btx = (x_b - 48 + 8) >> 4, bty = (y_b - 32 + 16) >> 4 (hitbox centre).
REQ-019 FSM states: NO_BOMB, FUSE, EXPLODE, POST_EXP; single 28-bit timer, cleared on every state entry.
REQ-020 NO_BOMB -> FUSE on rising edge of btn_place (registered edge detect); bomb tile latched in the same cycle.
REQ-021 btn_place edges in FUSE, EXPLODE, POST_EXP are ignored; a button held through POST_EXP does not re-place (edge required).
REQ-022 FUSE -> EXPLODE when timer == FUSE_MAX-1; EXPLODE -> POST_EXP when timer == EXP_MAX-1; POST_EXP -> NO_BOMB when timer == POST_MAX-1.
REQ-023 On EXPLODE entry, arm tiles computed once: per direction (U,D,L,R), tiles at distance 1..EXP_LEN included until first pillar or out-of-arena tile; that tile and beyond excluded.
REQ-024 Explosion set = bomb tile plus included arm tiles; held constant through EXPLODE.
REQ-025 bomb_on = display_on and state FUSE and pixel tile == bomb tile.
REQ-026 exp_on = display_on and state EXPLODE and pixel tile in explosion set; pixels outside arena never assert.
REQ-027 post_exp_active = 1 in EXPLODE and POST_EXP, 0 otherwise (registered from state).
REQ-028 bm_exp_hit pulses exactly once per explosion, in the first EXPLODE cycle where bomberman hitbox-centre tile (per REQ-018 formula on current x_b,y_b) is in the explosion set.
REQ-029 rgb_out: bomb_on -> 12'h000 when timer[23]=0, 12'hF00 when 1; exp_on -> 12'hFA0; else 12'h000.
REQ-030 bomb_on, exp_on, rgb_out combinational from registers and x,y; no added pixel latency.

Reset
REQ-031 reset forces NO_BOMB, timer 0, bomb tile 0, explosion set empty, button edge register 0, bm_exp_hit latch cleared.
REQ-032 All outputs 0 during and after reset until next valid placement; reset mid-FUSE/EXPLODE aborts with no explosion pulse.

Verification (FUSE_MAX=20, EXP_MAX=10, POST_MAX=5, EXP_LEN=1)
REQ-033 x_b=48,y_b=24, btn rising -> bomb_active next cycle, tile (0,0); after 20 cycles exp_on at (0,0),(1,0),(0,1); up/left arms excluded.
REQ-034 Bomb at tile (2,1): right arm excluded? no -- left tile (1,1) pillar excluded, right (3,1) pillar excluded, (2,0),(2,2) included.
REQ-035 Bomberman stays on bomb tile -> bm_exp_hit single pulse first EXPLODE cycle; post_exp_active high 15 cycles total, then 0.
REQ-036 btn_place toggled during FUSE and held through POST_EXP -> no new bomb; release and press again -> new FUSE.
REQ-037 reset asserted mid-EXPLODE -> exp_on, post_exp_active, bomb_active 0 immediately; no bm_exp_hit.

Source files
------------

// File: rtl/bomb_exp_module.sv
// Bomb placement, fuse countdown and cross-shaped explosion for the arena renderer.
// Tile lookups are combinational on the pixel coordinates, so the outputs add no pixel latency.
module bomb_exp_module #(
  parameter int FUSE_MAX = 150000000,
  parameter int EXP_MAX  = 50000000,
  parameter int POST_MAX = 25000000,
  parameter int EXP_LEN  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        display_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [9:0]  x_b,
  input  logic [9:0]  y_b,
  input  logic        btn_place,
  output logic        bomb_on,
  output logic        exp_on,
  output logic        post_exp_active,
  output logic        bomb_active,
  output logic        bm_exp_hit,
  output logic [11:0] rgb_out
);

  typedef enum logic [1:0] {NO_BOMB, FUSE, EXPLODE, POST_EXP} state_t;

  state_t            state, state_nxt;
  logic [27:0]       timer;
  logic              btn_q, btn_rise;
  logic signed [7:0] btx, bty, pix_tx, pix_ty, bm_tx, bm_ty;
  logic [7:0]        arms;
  logic              hit_done, hit_now, pix_in;
  logic              unused_bits;

  function automatic logic blocked(input logic signed [7:0] tx, input logic signed [7:0] ty);
    return (tx < 8'sd0) || (tx > 8'sd32) || (ty < 8'sd0) || (ty > 8'sd25) || (tx[0] && ty[0]);
  endfunction

  // Reach of one arm: stops just before the first pillar or arena edge.
  function automatic logic [1:0] arm_len(input logic signed [7:0] bx, input logic signed [7:0] by,
                                         input logic signed [7:0] dx, input logic signed [7:0] dy);
    logic signed [7:0] nx, ny;
    logic              stop;
    logic [1:0]        len;
    nx   = bx;
    ny   = by;
    stop = 1'b0;
    len  = 2'd0;
    for (int d = 1; d <= 3; d++) begin
      nx = nx + dx;
      ny = ny + dy;
      if (d <= EXP_LEN && !stop) begin
        if (blocked(nx, ny)) stop = 1'b1;
        else len = 2'(d);
      end
    end
    return len;
  endfunction

  // arms packs the reach as {up, down, left, right}, two bits each.
  function automatic logic in_set(input logic signed [7:0] tx, input logic signed [7:0] ty,
                                  input logic signed [7:0] bx, input logic signed [7:0] by,
                                  input logic [7:0] a);
    logic signed [7:0] dx, dy;
    dx = tx - bx;
    dy = ty - by;
    return (dx == 8'sd0 && dy == 8'sd0)
        || (dx == 8'sd0 && dy < 8'sd0 && -dy <= $signed({6'b0, a[7:6]}))
        || (dx == 8'sd0 && dy > 8'sd0 &&  dy <= $signed({6'b0, a[5:4]}))
        || (dy == 8'sd0 && dx < 8'sd0 && -dx <= $signed({6'b0, a[3:2]}))
        || (dy == 8'sd0 && dx > 8'sd0 &&  dx <= $signed({6'b0, a[1:0]}));
  endfunction

  // The arena origin (48,32) is tile aligned, so pixel tiles are plain bit slices.
  assign pix_tx = $signed({2'b00, x[9:4]}) - 8'sd3;
  assign pix_ty = $signed({2'b00, y[9:4]}) - 8'sd2;
  assign pix_in = (pix_tx >= 8'sd0) && (pix_tx <= 8'sd32) && (pix_ty >= 8'sd0) && (pix_ty <= 8'sd25);
  // Hitbox centre (+8,+16): x_b[3] carries the half-tile offset into the tile index.
  assign bm_tx  = $signed({2'b00, x_b[9:4]}) + $signed({7'b0, x_b[3]}) - 8'sd3;
  assign bm_ty  = $signed({2'b00, y_b[9:4]}) - 8'sd1;
  assign unused_bits = ^{x[3:0], y[3:0], x_b[2:0], y_b[3:0]};

  assign btn_rise = btn_place & ~btn_q;

  always_comb begin
    state_nxt = state;
    case (state)
      NO_BOMB:  if (btn_rise)                       state_nxt = FUSE;
      FUSE:     if (timer == 28'(FUSE_MAX - 1))     state_nxt = EXPLODE;
      EXPLODE:  if (timer == 28'(EXP_MAX - 1))      state_nxt = POST_EXP;
      POST_EXP: if (timer == 28'(POST_MAX - 1))     state_nxt = NO_BOMB;
      default:                                      state_nxt = NO_BOMB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= NO_BOMB;
      timer           <= '0;
      btn_q           <= 1'b0;
      btx             <= '0;
      bty             <= '0;
      arms            <= '0;
      hit_done        <= 1'b0;
      post_exp_active <= 1'b0;
    end else begin
      btn_q <= btn_place;
      state <= state_nxt;
      if (state_nxt != state || state_nxt == NO_BOMB) timer <= '0;
      else timer <= timer + 28'd1;
      if (state == NO_BOMB && btn_rise) begin
        btx <= bm_tx;
        bty <= bm_ty;
      end
      if (state == FUSE && state_nxt == EXPLODE) begin
        arms     <= {arm_len(btx, bty, 8'sd0, -8'sd1), arm_len(btx, bty, 8'sd0, 8'sd1),
                     arm_len(btx, bty, -8'sd1, 8'sd0), arm_len(btx, bty, 8'sd1, 8'sd0)};
        hit_done <= 1'b0;
      end else if (hit_now) begin
        hit_done <= 1'b1;
      end
      post_exp_active <= (state_nxt == EXPLODE) || (state_nxt == POST_EXP);
    end
  end

  assign bomb_active = (state != NO_BOMB);
  assign bomb_on     = display_on && (state == FUSE) && pix_in && (pix_tx == btx) && (pix_ty == bty);
  assign exp_on      = display_on && (state == EXPLODE) && pix_in && in_set(pix_tx, pix_ty, btx, bty, arms);
  assign hit_now     = (state == EXPLODE) && !hit_done && in_set(bm_tx, bm_ty, btx, bty, arms);
  assign bm_exp_hit  = hit_now;

  always_comb begin
    rgb_out = 12'h000;
    if (bomb_on)     rgb_out = timer[23] ? 12'hF00 : 12'h000;
    else if (exp_on) rgb_out = 12'hFA0;
  end

endmodule
